// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, requests to send, then
// shifts one command byte out on device-generated clock falls and checks the ack.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_ack_err,
  output logic       tx_timeout,
  output logic [2:0] state_dbg
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, RELEASE, SEND, FINISH, DONE, ERR
  } state_t;

  state_t          state, state_next;
  logic [1:0]      clk_sync, data_sync;
  logic            clk_filt, fall_pulse;
  logic [FW-1:0]   filt_cnt;
  logic [IW-1:0]   inh_cnt;
  logic [TW-1:0]   gap_cnt;
  logic [3:0]      bit_cnt;
  logic [8:0]      shift;

  // Clock level is only accepted after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_sync   <= 2'b11;
      data_sync  <= 2'b11;
      clk_filt   <= 1'b1;
      filt_cnt   <= '0;
      fall_pulse <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk_in};
      data_sync  <= {data_sync[0], ps2_data_in};
      fall_pulse <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        clk_filt   <= clk_sync[1];
        filt_cnt   <= '0;
        fall_pulse <= clk_filt;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      inh_cnt    <= '0;
      gap_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      tx_ack_err <= 1'b0;
      tx_timeout <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next == ERR) tx_timeout <= 1'b1;
      case (state)
        IDLE: if (tx_start) begin
          shift      <= {~^tx_data, tx_data};
          tx_ack_err <= 1'b0;
          tx_timeout <= 1'b0;
          inh_cnt    <= '0;
        end
        INHIBIT: inh_cnt <= inh_cnt + 1'b1;
        RTS:     gap_cnt <= '0;
        RELEASE: begin
          gap_cnt <= gap_cnt + 1'b1;
          bit_cnt <= '0;
        end
        SEND: if (fall_pulse) begin
          gap_cnt <= '0;
          bit_cnt <= bit_cnt + 1'b1;
          // Bit 0 is shown after the first fall; shift only after it has been on the line.
          if (bit_cnt >= 4'd1 && bit_cnt <= 4'd8) shift <= {1'b0, shift[8:1]};
          if (bit_cnt == 4'd10) tx_ack_err <= data_sync[1];
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
        FINISH:  gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tx_start) state_next = INHIBIT;
      INHIBIT: if (inh_cnt == INH_LAST) state_next = RTS;
      RTS:     state_next = RELEASE;
      RELEASE: begin
        // Our own clock drive kept the filter low; wait for the released line.
        if (gap_cnt == GAP_LAST) state_next = ERR;
        else if (clk_filt)       state_next = SEND;
      end
      SEND: begin
        if (fall_pulse) begin
          if (bit_cnt == 4'd10) state_next = FINISH;
        end else if (gap_cnt == GAP_LAST) begin
          state_next = ERR;
        end
      end
      FINISH: begin
        if (gap_cnt == GAP_LAST) state_next = ERR;
        else if (clk_filt)       state_next = DONE;
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ps2_clk_drive_low  = (state == INHIBIT) || (state == RTS);
    ps2_data_drive_low = 1'b0;
    case (state)
      RTS, RELEASE: ps2_data_drive_low = 1'b1;
      SEND: begin
        if (bit_cnt == 4'd0)      ps2_data_drive_low = 1'b1;
        else if (bit_cnt <= 4'd9) ps2_data_drive_low = ~shift[0];
      end
      default: ;
    endcase
  end

  assign tx_busy   = (state != IDLE);
  assign tx_done   = (state == DONE) || (state == ERR);
  assign state_dbg = state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host
// and a table of command bytes with hand-computed frames drives the checks.
module tb_ps2_host_tx;

  localparam int INH  = 50;
  localparam int TMO  = 2000;
  localparam int FLT  = 8;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_drive_low, ps2_data_drive_low;
  logic       tx_busy, tx_done, tx_ack_err, tx_timeout;
  logic [2:0] state_dbg;

  // Open-collector bus: either side pulling low wins.
  assign ps2_clk_in  = ~(ps2_clk_drive_low | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_drive_low | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FLT)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_drive_low(ps2_clk_drive_low), .ps2_data_drive_low(ps2_data_drive_low),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_ack_err(tx_ack_err),
    .tx_timeout(tx_timeout), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // mode: 0 plain, 1 reset after 4th fall, 2 tx_start poke + short clock glitch
  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic [8:0] frame;
    logic       exp_err;
    int         mode;
  } vec_t;

  vec_t        vecs[5];
  logic [10:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        prev_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic measure_inhibit();
    int inh = 0;
    int rts = 0;
    while (ps2_clk_drive_low && !ps2_data_drive_low && inh < INH + 10) begin
      inh++;
      @(negedge clk);
    end
    while (ps2_clk_drive_low && ps2_data_drive_low && rts < 10) begin
      rts++;
      @(negedge clk);
    end
    check("inhibit_len", inh, INH);
    check("rts_len", rts, 1);
    check("release_start_bit", {ps2_clk_drive_low, ps2_data_drive_low}, 2'b01);
  endtask

  // Device: 11 clock pulses, samples the data line at the end of each low phase.
  task automatic dev_clock(input logic ack, input int mode,
                           output logic [10:0] bits, output logic aborted);
    aborted = 1'b0;
    bits    = '0;
    repeat (HALF) @(negedge clk);
    bits[0] = ps2_data_in;
    for (int i = 1; i <= 11; i++) begin
      dev_clk_low = 1'b1;
      if (i == 11) dev_data_low = ack;
      if (i == 4 && mode == 1) begin
        repeat (15) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rst_mid_drives", {ps2_clk_drive_low, ps2_data_drive_low}, 2'b00);
        check("rst_mid_busy", tx_busy, 0);
        check("rst_mid_state", state_dbg, 0);
        dev_clk_low = 1'b0;
        aborted = 1'b1;
        repeat (HALF) @(negedge clk);
        return;
      end
      for (int c = 0; c < HALF - 1; c++) begin
        @(negedge clk);
        tx_start = (mode == 2 && i == 5 && c == 5);
        if (tx_start) tx_data = 8'h00;
      end
      if (i <= 10) bits[i] = ps2_data_in;
      @(negedge clk);
      dev_clk_low = 1'b0;
      if (i < 11) begin
        for (int c = 0; c < HALF; c++) begin
          @(negedge clk);
          dev_clk_low = (mode == 2 && i == 4 && c >= 10 && c < 13);
        end
      end
    end
    dev_data_low = 1'b0;
  endtask

  task automatic do_transfer(input vec_t v);
    logic [10:0] bits, exp;
    logic        aborted;
    int          n = 0;
    check("ack_err_hold", tx_ack_err, prev_err);
    exp_q.push_back({1'b1, v.frame, 1'b0});
    start_tx(v.data);
    check("accept_busy", tx_busy, 1);
    check("accept_ack_err_clear", tx_ack_err, 0);
    check("accept_timeout_clear", tx_timeout, 0);
    measure_inhibit();
    dev_clock(v.ack, v.mode, bits, aborted);
    exp = exp_q.pop_front();
    if (aborted) begin
      prev_err = 1'b0;
      return;
    end
    check("frame_bits", bits, exp);
    while (!tx_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", tx_done, 1);
    check("done_ack_err", tx_ack_err, v.exp_err);
    check("done_timeout", tx_timeout, 0);
    check("done_busy", tx_busy, 1);
    @(negedge clk);
    check("done_one_cycle", tx_done, 0);
    check("busy_after_done", tx_busy, 0);
    check("ack_err_after_done", tx_ack_err, v.exp_err);
    prev_err = v.exp_err;
  endtask

  task automatic timeout_seq();
    int n = 0;
    check("ack_err_hold", tx_ack_err, prev_err);
    start_tx(8'hF4);
    measure_inhibit();
    while (!tx_done && n < TMO + 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, TMO);
    check("timeout_flag", tx_timeout, 1);
    check("timeout_drives", {ps2_clk_drive_low, ps2_data_drive_low}, 2'b00);
    check("timeout_ack_err", tx_ack_err, 0);
    @(negedge clk);
    check("timeout_idle", state_dbg, 0);
    check("timeout_busy", tx_busy, 0);
    check("timeout_held", tx_timeout, 1);
    prev_err = 1'b0;
  endtask

  initial begin
    // parity bit (odd) is the MSB of each hand-computed frame
    vecs[0] = '{data: 8'hF4, ack: 1'b1, frame: 9'h0F4, exp_err: 1'b0, mode: 0};
    vecs[1] = '{data: 8'hED, ack: 1'b1, frame: 9'h1ED, exp_err: 1'b0, mode: 0};
    vecs[2] = '{data: 8'hFF, ack: 1'b0, frame: 9'h1FF, exp_err: 1'b1, mode: 0};
    vecs[3] = '{data: 8'hF4, ack: 1'b1, frame: 9'h0F4, exp_err: 1'b0, mode: 2};
    vecs[4] = '{data: 8'hF4, ack: 1'b1, frame: 9'h0F4, exp_err: 1'b0, mode: 1};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {ps2_clk_drive_low, ps2_data_drive_low, tx_busy, tx_done, tx_ack_err, tx_timeout},
          6'b0);
    check("reset_state", state_dbg, 0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      do_transfer(vecs[i]);
      repeat (10) @(negedge clk);
    end
    timeout_seq();
    repeat (10) @(negedge clk);
    do_transfer(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
